p4_router_vnp4_metadata_aligner: RTL and testbench
==================================================

Name: p4_router_vnp4_metadata_aligner

Overview:
Parametrised sideband companion for a Vitis Net P4 core that carries an arbitrary number of ports.
- Ingress side: monitors the ingress packet stream and emits a one-cycle metadata-valid strobe with the ingress port on each start-of-frame (SOF).
- Egress side: buffers the core's per-packet output metadata in a FIFO and maps each P4 egress spec to a physical port through a runtime-programmable table.
- Re-attaches the mapped port as tuser on every beat of the matching output packet, or drops packets whose egress spec is unmapped.

Parameters:
NUM_PORTS, 8, number of physical ports; P4 egress-spec space is also NUM_PORTS entries
PORT_W, $clog2(NUM_PORTS), width of port ids
DATA_BYTES, 64, AXIS tdata bytes
MD_FIFO_DEPTH, 16, metadata FIFO entries; power of two, >=2
DROP_UNMAPPED, 1, 1 = drop packets with an unmapped egress spec; 0 = send them to EGR_DEFAULT
EGR_DEFAULT, 0, physical port used for unmapped specs when DROP_UNMAPPED=0
CNT_W, 32, drop counter width

Ports:
clk  in  1  single clock for all logic
areset  in  1  asynchronous, active-high reset
s_tvalid  in  1  ingress stream valid (monitor only)
s_tready  in  1  ingress stream ready (monitor only)
s_tlast  in  1  ingress stream last (monitor only)
s_ing_port  in  PORT_W  ingress physical port of the current beat
md_in_ing_port  out  PORT_W  ingress port presented to the core
md_in_valid  out  1  one-cycle SOF strobe to the core's user_metadata_in_valid
core_md_egr_spec  in  PORT_W  core user_metadata_out.egr_spec
core_md_ing_port  in  PORT_W  core user_metadata_out.ing_port
core_md_valid  in  1  core user_metadata_out_valid
core_tdata  in  8*DATA_BYTES  core output tdata
core_tkeep  in  DATA_BYTES  core output tkeep
core_tlast  in  1  core output tlast
core_tvalid  in  1  core output tvalid
core_tready  out  1  ready back to the core
m_tdata  out  8*DATA_BYTES  egress tdata
m_tkeep  out  DATA_BYTES  egress tkeep
m_tlast  out  1  egress tlast
m_tvalid  out  1  egress tvalid
m_tready  in  1  egress tready
m_tuser_egr_port  out  PORT_W  mapped physical egress port
m_tuser_ing_port  out  PORT_W  ingress port from core metadata
map_wr_en  in  1  egress map write strobe
map_wr_addr  in  PORT_W  egress spec index to write
map_wr_port  in  PORT_W  physical port for that spec
map_wr_valid  in  1  entry-valid bit written with the entry
drop_count  out  CNT_W  saturating count of dropped packets
md_overflow  out  1  sticky: metadata arrived while the FIFO was full
md_overflow_clr  in  1  clears md_overflow
fifo_level  out  $clog2(MD_FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
Reset (asynchronous, active-high):
- All outputs 0; FIFO empty; FSM in IDLE; in_sof=1.
- All map entries invalid; drop_count=0; md_overflow=0.
- A reset asserted mid-packet aborts the packet; no partial-state recovery is provided.

Ingress monitor:
- in_sof is set on an accepted beat with tlast=1 and cleared on an accepted beat with tlast=0.
- md_in_valid = s_tvalid & s_tready & in_sof, combinational, in the same cycle as the first beat.
- md_in_ing_port = s_ing_port (pass-through).
- A single-beat packet produces exactly one strobe.

Metadata FIFO:
- Each entry holds {egr_spec, ing_port}.
- Push on core_md_valid.
- Push while full is accepted only if a pop occurs in the same cycle; otherwise the entry is discarded and md_overflow is set.
- Simultaneous push and pop leaves fifo_level unchanged.
- md_overflow_clr clears the flag; a set in the same cycle wins over the clear.

Egress FSM (IDLE, PASS, DROP):
- IDLE:
  - core_tready=0 and m_tvalid=0.
  - When the FIFO is non-empty and core_tvalid=1: pop the FIFO and read map[egr_spec].
  - If the entry is valid: register m_tuser_egr_port = entry port and go to PASS.
  - If the entry is invalid and DROP_UNMAPPED=0: register EGR_DEFAULT and go to PASS.
  - If the entry is invalid and DROP_UNMAPPED=1: increment drop_count (saturating at all-ones) and go to DROP.
  - m_tuser_ing_port is registered from the popped entry.
- PASS:
  - m_* = core_* combinationally; core_tready = m_tready.
  - tuser stays constant for the whole packet.
  - Accepted beat with tlast=1 returns the FSM to IDLE.
- DROP:
  - core_tready=1 and m_tvalid=0.
  - Accepted beat with tlast=1 returns the FSM to IDLE.

Timing and map updates:
- Latency: one bubble cycle per packet (the IDLE decision cycle); no bubbles within a packet.
- A map write takes effect on the next IDLE lookup; a packet already in PASS keeps its tuser.
- A write and a lookup to the same entry in the same cycle return the old value.

Test Plan:
- Ingress SOF strobe: 3 packets of lengths 1, 4 and 2 beats with s_ing_port 2, 5, 7 -> exactly 3 md_in_valid pulses, one on each first beat, with md_in_ing_port 2, 5, 7.
- Mapped forwarding: map[3]=6 valid; metadata egr_spec=3, ing_port=1, then a 4-beat packet with m_tready=1 -> 4 output beats, tuser_egr_port=6 and tuser_ing_port=1 on every beat, one bubble before beat 0.
- Unmapped drop: DROP_UNMAPPED=1, spec 4 invalid, 3-beat packet -> core_tready=1 for 3 beats, m_tvalid never asserted, drop_count=1; following mapped packet forwards normally.
- Backpressure and map change: random m_tready at 50% over a 6-beat packet while map[3] is rewritten to 2 mid-packet -> data intact and tuser stays 6; the next packet uses 2.
- FIFO overflow: 17 core_md_valid pulses with no output accepted (depth 16) -> fifo_level=16, md_overflow=1; md_overflow_clr -> flag 0. Then push and pop in the same cycle while full -> level stays 16, no overflow.
- Async reset mid-packet: assert areset during beat 2 of 5 -> all outputs 0 immediately, fifo_level=0, map entries invalid, drop_count=0; the next packet requires fresh metadata.

Source files
------------

// File: rtl/p4_router_vnp4_metadata_aligner_if.sv
// AXI-Stream data channel used on both the core side and the egress side of the aligner.
interface p4_router_vnp4_metadata_aligner_if #(
    parameter int unsigned DATA_BYTES = 64
);
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/p4_router_vnp4_metadata_aligner.sv
// Sideband companion for a Vitis Net P4 core: SOF metadata strobe on ingress, per-packet
// egress-spec to physical-port mapping re-attached as tuser (or packet drop) on egress.
module p4_router_vnp4_metadata_aligner #(
    parameter int unsigned NUM_PORTS     = 8,
    parameter int unsigned PORT_W        = $clog2(NUM_PORTS),
    parameter int unsigned DATA_BYTES    = 64,
    parameter int unsigned MD_FIFO_DEPTH = 16,
    parameter bit          DROP_UNMAPPED = 1'b1,
    parameter int unsigned EGR_DEFAULT   = 0,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                             clk,
    input  logic                             areset,
    input  logic                             s_tvalid,
    input  logic                             s_tready,
    input  logic                             s_tlast,
    input  logic [PORT_W-1:0]                s_ing_port,
    output logic [PORT_W-1:0]                md_in_ing_port,
    output logic                             md_in_valid,
    input  logic [PORT_W-1:0]                core_md_egr_spec,
    input  logic [PORT_W-1:0]                core_md_ing_port,
    input  logic                             core_md_valid,
    p4_router_vnp4_metadata_aligner_if.slave  core,
    p4_router_vnp4_metadata_aligner_if.master m,
    output logic [PORT_W-1:0]                m_tuser_egr_port,
    output logic [PORT_W-1:0]                m_tuser_ing_port,
    input  logic                             map_wr_en,
    input  logic [PORT_W-1:0]                map_wr_addr,
    input  logic [PORT_W-1:0]                map_wr_port,
    input  logic                             map_wr_valid,
    output logic [CNT_W-1:0]                 drop_count,
    output logic                             md_overflow,
    input  logic                             md_overflow_clr,
    output logic [$clog2(MD_FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned AW = $clog2(MD_FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                r_in_sof;
    logic [2*PORT_W-1:0] r_fifo_mem [MD_FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [LW-1:0]       r_level;
    logic [PORT_W-1:0]   r_map_port [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_map_vld;
    logic [PORT_W-1:0]   r_tuser_egr;
    logic [PORT_W-1:0]   r_tuser_ing;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic                r_overflow;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_ovf_set;
    logic [2*PORT_W-1:0] w_rd_entry;
    logic [PORT_W-1:0]   w_rd_spec;
    logic [PORT_W-1:0]   w_rd_ing;
    logic                w_map_hit;
    logic                w_load_tuser;
    logic [PORT_W-1:0]   w_tuser_egr;
    logic                w_drop_inc;

    // Ingress monitor
    assign md_in_valid    = s_tvalid & s_tready & r_in_sof;
    assign md_in_ing_port = s_ing_port;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_in_sof <= 1'b1;
        end else if (s_tvalid && s_tready) begin
            r_in_sof <= s_tlast;
        end
    end

    // Metadata FIFO
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(MD_FIFO_DEPTH));
    // When full, the pop frees the slot that wr_ptr (== rd_ptr) overwrites at the same edge.
    assign w_push     = core_md_valid && (!w_full || w_pop);
    assign w_ovf_set  = core_md_valid && w_full && !w_pop;
    assign w_rd_entry = r_fifo_mem[r_rd_ptr];
    assign w_rd_spec  = w_rd_entry[2*PORT_W-1:PORT_W];
    assign w_rd_ing   = w_rd_entry[PORT_W-1:0];
    assign w_map_hit  = (int'(w_rd_spec) < int'(NUM_PORTS)) && r_map_vld[w_rd_spec];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {core_md_egr_spec, core_md_ing_port};
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (md_overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Egress map; lookups read the pre-write value in a write/lookup collision
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_map_vld <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                r_map_port[i] <= '0;
            end
        end else if (map_wr_en && (int'(map_wr_addr) < int'(NUM_PORTS))) begin
            r_map_port[map_wr_addr] <= map_wr_port;
            r_map_vld[map_wr_addr]  <= map_wr_valid;
        end
    end

    // Egress FSM
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_load_tuser = 1'b0;
        w_tuser_egr  = '0;
        w_drop_inc   = 1'b0;
        core.tready  = 1'b0;
        m.tvalid     = 1'b0;
        m.tdata      = '0;
        m.tkeep      = '0;
        m.tlast      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && core.tvalid) begin
                    w_pop        = 1'b1;
                    w_load_tuser = 1'b1;
                    if (w_map_hit) begin
                        w_tuser_egr = r_map_port[w_rd_spec];
                        w_state_nxt = PASS;
                    end else if (!DROP_UNMAPPED) begin
                        w_tuser_egr = PORT_W'(EGR_DEFAULT);
                        w_state_nxt = PASS;
                    end else begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = DROP;
                    end
                end
            end
            PASS: begin
                m.tvalid    = core.tvalid;
                m.tdata     = core.tdata;
                m.tkeep     = core.tkeep;
                m.tlast     = core.tlast;
                core.tready = m.tready;
                if (core.tvalid && m.tready && core.tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                core.tready = 1'b1;
                if (core.tvalid && core.tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_tuser_egr <= '0;
            r_tuser_ing <= '0;
        end else if (w_load_tuser) begin
            r_tuser_egr <= w_tuser_egr;
            r_tuser_ing <= w_rd_ing;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_drop_cnt <= '0;
        end else if (w_drop_inc && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign m_tuser_egr_port = r_tuser_egr;
    assign m_tuser_ing_port = r_tuser_ing;
    assign drop_count       = r_drop_cnt;
    assign md_overflow      = r_overflow;
    assign fifo_level       = r_level;
endmodule

// File: tb/tb_p4_router_vnp4_metadata_aligner.sv
// Scoreboard bench for the metadata aligner: expected egress beats are queued as packets are driven.
module tb_p4_router_vnp4_metadata_aligner;
    localparam int NP = 8;
    localparam int PW = 3;
    localparam int DB = 64;
    localparam int CW = 32;

    typedef struct {
        logic [8*DB-1:0] data;
        logic [DB-1:0]   keep;
        logic            last;
        logic [PW-1:0]   egr;
        logic [PW-1:0]   ing;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    n_cmp = 0;
    int    n_err = 0;

    logic          clk;
    logic          areset;
    logic          s_tvalid, s_tready, s_tlast;
    logic [PW-1:0] s_ing_port;
    logic [PW-1:0] md_in_ing_port;
    logic          md_in_valid;
    logic [PW-1:0] core_md_egr_spec, core_md_ing_port;
    logic          core_md_valid;
    logic [PW-1:0] m_tuser_egr_port, m_tuser_ing_port;
    logic          map_wr_en;
    logic [PW-1:0] map_wr_addr, map_wr_port;
    logic          map_wr_valid;
    logic [CW-1:0] drop_count;
    logic          md_overflow, md_overflow_clr;
    logic [4:0]    fifo_level;
    bit            rand_rdy = 1'b0;

    p4_router_vnp4_metadata_aligner_if #(.DATA_BYTES(DB)) core_if ();
    p4_router_vnp4_metadata_aligner_if #(.DATA_BYTES(DB)) m_if ();

    p4_router_vnp4_metadata_aligner #(
        .NUM_PORTS(NP), .PORT_W(PW), .DATA_BYTES(DB), .MD_FIFO_DEPTH(16),
        .DROP_UNMAPPED(1'b1), .EGR_DEFAULT(0), .CNT_W(CW)
    ) dut (
        .clk(clk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_ing_port(s_ing_port),
        .md_in_ing_port(md_in_ing_port), .md_in_valid(md_in_valid),
        .core_md_egr_spec(core_md_egr_spec), .core_md_ing_port(core_md_ing_port),
        .core_md_valid(core_md_valid),
        .core(core_if.slave), .m(m_if.master),
        .m_tuser_egr_port(m_tuser_egr_port), .m_tuser_ing_port(m_tuser_ing_port),
        .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_port(map_wr_port),
        .map_wr_valid(map_wr_valid), .drop_count(drop_count),
        .md_overflow(md_overflow), .md_overflow_clr(md_overflow_clr), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
        end
    end

    // Egress monitor: every presented beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (!areset && m_if.tvalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: m_tvalid=1 data=%h required no egress beat", m_if.tdata[31:0]);
            end else if (m_if.tready) begin
                mon_b = exp_q.pop_front();
                n_cmp++;
                if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_tuser_egr_port, m_tuser_ing_port} !==
                    {mon_b.data, mon_b.keep, mon_b.last, mon_b.egr, mon_b.ing}) begin
                    n_err++;
                    $display("FAIL egress_beat: data=%h keep=%h last=%b egr=%0d ing=%0d required data=%h keep=%h last=%b egr=%0d ing=%0d",
                             m_if.tdata[31:0], m_if.tkeep, m_if.tlast, m_tuser_egr_port, m_tuser_ing_port,
                             mon_b.data[31:0], mon_b.keep, mon_b.last, mon_b.egr, mon_b.ing);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic map_write(input logic [PW-1:0] a, input logic [PW-1:0] p, input logic v);
        map_wr_en = 1'b1; map_wr_addr = a; map_wr_port = p; map_wr_valid = v;
        tick();
        map_wr_en = 1'b0;
    endtask

    task automatic push_md(input logic [PW-1:0] spec, input logic [PW-1:0] ing);
        core_md_valid = 1'b1; core_md_egr_spec = spec; core_md_ing_port = ing;
        tick();
        core_md_valid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] tag, input bit pass,
                            input logic [PW-1:0] egr, input logic [PW-1:0] ing, output int stalls);
        stalls = 0;
        for (int b = 0; b < n; b++) begin
            beat_t e;
            int    w;
            e.data = {16{tag + 32'(b)}};
            e.keep = {DB{1'b1}} >> (b % 4);
            e.last = (b == n - 1);
            e.egr  = egr;
            e.ing  = ing;
            if (pass) exp_q.push_back(e);
            core_if.tdata  = e.data;
            core_if.tkeep  = e.keep;
            core_if.tlast  = e.last;
            core_if.tvalid = 1'b1;
            w = 0;
            forever begin
                @(negedge clk);
                if (core_if.tready) break;
                w++;
                stalls++;
                if (w > 100) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL send_timeout: core_tready=0 for %0d cycles on beat %0d, required acceptance", w, b);
                    core_if.tvalid = 1'b0;
                    return;
                end
                tick();
            end
            tick();
        end
        core_if.tvalid = 1'b0;
        core_if.tlast  = 1'b0;
    endtask

    task automatic check_drained(input string name);
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            tick();
            w++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m_if.tvalid, core_if.tready, md_in_valid, m_tuser_egr_port, m_tuser_ing_port, md_overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: m_tvalid=%b core_tready=%b md_in_valid=%b egr=%0d ing=%0d ovf=%b required all 0",
                     m_if.tvalid, core_if.tready, md_in_valid, m_tuser_egr_port, m_tuser_ing_port, md_overflow);
        end
        n_cmp++;
        if (fifo_level !== 5'd0 || drop_count !== '0) begin
            n_err++;
            $display("FAIL reset_counters: fifo_level=%0d drop_count=%0d required 0/0", fifo_level, drop_count);
        end
        tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic test_ingress_sof();
        int lens[3]  = '{1, 4, 2};
        int ports[3] = '{2, 5, 7};
        int pulses = 0;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < lens[p]; b++) begin
                s_tvalid = 1'b1; s_tready = 1'b1;
                s_tlast = (b == lens[p] - 1);
                s_ing_port = PW'(ports[p]);
                @(negedge clk);
                n_cmp++;
                if (md_in_valid !== 1'(b == 0)) begin
                    n_err++;
                    $display("FAIL sof_strobe: pkt %0d beat %0d md_in_valid=%b required %b", p, b, md_in_valid, b == 0);
                end
                if (b == 0) begin
                    n_cmp++;
                    if (md_in_ing_port !== PW'(ports[p])) begin
                        n_err++;
                        $display("FAIL sof_port: pkt %0d md_in_ing_port=%0d required %0d", p, md_in_ing_port, ports[p]);
                    end
                end
                if (md_in_valid) pulses++;
                tick();
            end
            s_tvalid = 1'b0;
            s_tlast = 1'b0;
            tick();
        end
        s_ing_port = '0;
        n_cmp++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL sof_count: pulses=%0d required 3", pulses);
        end
    endtask

    task automatic test_mapped();
        int st;
        m_if.tready = 1'b1;
        map_write(3'd3, 3'd6, 1'b1);
        push_md(3'd3, 3'd1);
        send_pkt(4, 32'h1000, 1'b1, 3'd6, 3'd1, st);
        n_cmp++;
        if (st != 1) begin
            n_err++;
            $display("FAIL mapped_bubble: stall cycles=%0d required 1", st);
        end
        check_drained("mapped");
    endtask

    task automatic test_drop();
        int st;
        push_md(3'd4, 3'd2);
        send_pkt(3, 32'h2000, 1'b0, 3'd0, 3'd0, st);
        n_cmp++;
        if (st != 1) begin
            n_err++;
            $display("FAIL drop_ready: stall cycles=%0d required 1", st);
        end
        n_cmp++;
        if (drop_count !== 32'd1) begin
            n_err++;
            $display("FAIL drop_count: drop_count=%0d required 1", drop_count);
        end
        map_write(3'd5, 3'd7, 1'b1);
        push_md(3'd5, 3'd3);
        send_pkt(2, 32'h3000, 1'b1, 3'd7, 3'd3, st);
        check_drained("after_drop");
    endtask

    task automatic test_backpressure();
        int st;
        push_md(3'd3, 3'd0);
        push_md(3'd3, 3'd5);
        rand_rdy = 1'b1;
        fork
            send_pkt(6, 32'h4000, 1'b1, 3'd6, 3'd0, st);
            begin
                repeat (4) tick();
                map_write(3'd3, 3'd2, 1'b1);
            end
        join
        send_pkt(2, 32'h5000, 1'b1, 3'd2, 3'd5, st);
        rand_rdy = 1'b0;
        m_if.tready = 1'b1;
        check_drained("backpressure");
    endtask

    task automatic test_overflow();
        int st;
        core_if.tvalid = 1'b0;
        core_md_valid = 1'b1; core_md_egr_spec = 3'd3; core_md_ing_port = 3'd6;
        repeat (17) tick();
        core_md_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fifo_level !== 5'd16 || md_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_full: fifo_level=%0d md_overflow=%b required 16/1", fifo_level, md_overflow);
        end
        tick();
        md_overflow_clr = 1'b1;
        tick();
        md_overflow_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (md_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clr: md_overflow=%b required 0", md_overflow);
        end
        tick();
        fork
            send_pkt(1, 32'h6000, 1'b1, 3'd2, 3'd6, st);
            begin
                core_md_valid = 1'b1; core_md_egr_spec = 3'd3; core_md_ing_port = 3'd6;
                tick();
                core_md_valid = 1'b0;
                @(negedge clk);
                n_cmp++;
                if (fifo_level !== 5'd16 || md_overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL push_pop_full: fifo_level=%0d md_overflow=%b required 16/0", fifo_level, md_overflow);
                end
            end
        join
        check_drained("overflow");
    endtask

    task automatic test_async_reset();
        int    st;
        int    seen_rdy = 0;
        beat_t e;
        m_if.tready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            e.data = {16{32'h7000 + 32'(b)}};
            e.keep = '1; e.last = 1'b0; e.egr = 3'd2; e.ing = 3'd6;
            exp_q.push_back(e);
        end
        core_if.tkeep = '1; core_if.tlast = 1'b0; core_if.tvalid = 1'b1;
        core_if.tdata = {16{32'h7000}};
        tick();
        tick();
        core_if.tdata = {16{32'h7001}};
        tick();
        core_if.tdata = {16{32'h7002}};
        #2;
        areset = 1'b1;
        #1;
        n_cmp++;
        if ({m_if.tvalid, core_if.tready, m_tuser_egr_port, m_tuser_ing_port, md_overflow} !== '0 || m_if.tdata !== '0) begin
            n_err++;
            $display("FAIL areset_outputs: m_tvalid=%b core_tready=%b egr=%0d ing=%0d tdata=%h required all 0",
                     m_if.tvalid, core_if.tready, m_tuser_egr_port, m_tuser_ing_port, m_if.tdata[31:0]);
        end
        n_cmp++;
        if (fifo_level !== 5'd0 || drop_count !== '0) begin
            n_err++;
            $display("FAIL areset_counters: fifo_level=%0d drop_count=%0d required 0/0", fifo_level, drop_count);
        end
        check_drained("pre_reset");
        core_if.tvalid = 1'b0;
        tick();
        areset = 1'b0;
        core_if.tdata = {16{32'h7100}};
        core_if.tlast = 1'b1;
        core_if.tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (core_if.tready) seen_rdy++;
            tick();
        end
        n_cmp++;
        if (seen_rdy != 0) begin
            n_err++;
            $display("FAIL no_md_stall: core_tready high %0d cycles, required 0 without metadata", seen_rdy);
        end
        core_if.tvalid = 1'b0;
        push_md(3'd3, 3'd1);
        send_pkt(1, 32'h8000, 1'b0, 3'd0, 3'd0, st);
        n_cmp++;
        if (drop_count !== 32'd1) begin
            n_err++;
            $display("FAIL map_cleared: drop_count=%0d required 1 (map entry invalid after reset)", drop_count);
        end
    endtask

    initial begin
        areset = 1'b1;
        s_tvalid = 1'b0; s_tready = 1'b0; s_tlast = 1'b0; s_ing_port = '0;
        core_md_valid = 1'b0; core_md_egr_spec = '0; core_md_ing_port = '0;
        core_if.tdata = '0; core_if.tkeep = '0; core_if.tlast = 1'b0; core_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        map_wr_en = 1'b0; map_wr_addr = '0; map_wr_port = '0; map_wr_valid = 1'b0;
        md_overflow_clr = 1'b0;

        test_reset();
        test_ingress_sof();
        test_mapped();
        test_drop();
        test_backpressure();
        test_overflow();
        test_async_reset();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
